// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-style core: fetch FSM states, datapath widths
// and the architectural reset PC.
package arm_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_register.sv
// Generic W-bit architectural register: async active-low reset to RESET_VAL,
// synchronous load when en is high.
module pc_register #(
  parameter int             W         = 32,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid
// handshake to instruction memory and holds the fetched word until Advance.
// Define FETCH_PERF_CNT_EN to add the FetchCount/StallCount performance counters.
module fetch_unit
  import arm_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                PCSrc,
  input  logic [ADDR_W-1:0]   BranchTarget,
  input  logic                Advance,
  output logic                IMemReq,
  output logic [ADDR_W-1:0]   IMemAddr,
  input  logic                IMemGnt,
  input  logic                IMemRValid,
  input  logic [INSTR_W-1:0]  IMemRData,
  output logic [INSTR_W-1:0]  Instr,
  output logic                InstrValid,
  output logic [ADDR_W-1:0]   PC,
  output logic [ADDR_W-1:0]   PCPlus4,
  output logic [ADDR_W-1:0]   PCPlus8
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         FetchCount,
  output logic [31:0]         StallCount
`endif
);

  fetch_state_e        state, state_nxt;
  logic [ADDR_W-1:0]   pc_q, pc_nxt, branch_aligned;
  logic [INSTR_W-1:0]  instr_q;
  logic                accept_rsp, accept_adv;

  assign accept_rsp = (state == S_WAIT) && IMemRValid;
  assign accept_adv = (state == S_HOLD) && Advance;

  // Low address bits of a branch target are architecturally meaningless.
  assign branch_aligned = BranchTarget & ~ADDR_W'(PC_STEP - 1);
  assign pc_nxt         = PCSrc ? branch_aligned : pc_q + ADDR_W'(PC_STEP);

  pc_register #(
    .W         (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk   (CLK),
    .rst_n (RESETn),
    .en    (accept_adv),
    .d     (pc_nxt),
    .q     (pc_q)
  );

  // NOTE: always_comb assigns a default first so no path leaves state_nxt
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (IMemGnt)    state_nxt = S_WAIT;
      S_WAIT:  if (IMemRValid) state_nxt = S_HOLD;
      S_HOLD:  if (Advance)    state_nxt = S_REQ;
      default:                 state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= S_REQ;
      instr_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept_rsp) instr_q <= IMemRData;
    end
  end

  // Request is masked while reset is held so the bus sees no fetch until release.
  assign IMemReq    = (state == S_REQ) && RESETn;
  assign IMemAddr   = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = (state == S_HOLD);
  assign PC         = pc_q;
  assign PCPlus4    = pc_q + ADDR_W'(PC_STEP);
  assign PCPlus8    = pc_q + ADDR_W'(2 * PC_STEP);

`ifdef FETCH_PERF_CNT_EN
  logic stall_cycle;
  assign stall_cycle = ((state == S_REQ) && !IMemGnt) || ((state == S_WAIT) && !IMemRValid);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (accept_rsp)  FetchCount <= FetchCount + 32'd1;
      if (stall_cycle) StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetch
// streams checked against a transaction-level PC/instruction model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        Advance;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRValid;
  logic [31:0] IMemRData;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] PCPlus8;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural PC and the last word delivered to decode.
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  always #5 CLK = ~CLK;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .Advance      (Advance),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemGnt      (IMemGnt),
    .IMemRValid   (IMemRValid),
    .IMemRData    (IMemRData),
    .Instr        (Instr),
    .InstrValid   (InstrValid),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .PCPlus8      (PCPlus8)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount   (FetchCount),
    .StallCount   (StallCount)
`endif
  );

  task automatic idle_inputs();
    PCSrc        = 1'b0;
    BranchTarget = 32'h0;
    Advance      = 1'b0;
    IMemGnt      = 1'b0;
    IMemRValid   = 1'b0;
    IMemRData    = 32'h0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESETn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge CLK);
    RESETn    = 1'b1;
    exp_pc    = 32'h0;
    exp_instr = 32'h0;
  endtask

  // Runs one fetch with the given grant/response waits; optional noise injects
  // ignored Advance and stray RValid pulses. Ends at a negedge in S_HOLD.
  task automatic fetch_one(input int gnt_wait, input int rsp_wait,
                           input logic [31:0] data, input bit noise);
    int guard = 0;
    while (IMemReq !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    n_tests++;
    if (IMemReq !== 1'b1) begin
      n_fail++;
      $display("FAIL req_timeout: IMemReq=%b required 1", IMemReq);
    end
    n_tests++;
    if (IMemAddr !== exp_pc) begin
      n_fail++;
      $display("FAIL req_addr: IMemAddr=%h required %h", IMemAddr, exp_pc);
    end
    for (int i = 0; i < gnt_wait; i++) begin
      IMemGnt = 1'b0;
      if (noise) begin
        IMemRValid   = 1'($urandom_range(0, 1));
        IMemRData    = $urandom;
        Advance      = 1'($urandom_range(0, 1));
        PCSrc        = 1'($urandom_range(0, 1));
        BranchTarget = $urandom;
      end
      @(negedge CLK);
      IMemRValid = 1'b0;
      Advance    = 1'b0;
      PCSrc      = 1'b0;
      n_tests++;
      if (IMemReq !== 1'b1 || IMemAddr !== exp_pc || InstrValid !== 1'b0 || Instr !== exp_instr) begin
        n_fail++;
        $display("FAIL gnt_stall: req=%b addr=%h valid=%b instr=%h required req=1 addr=%h valid=0 instr=%h",
                 IMemReq, IMemAddr, InstrValid, Instr, exp_pc, exp_instr);
      end
    end
    IMemGnt = 1'b1;
    @(negedge CLK);
    IMemGnt = 1'b0;
    n_tests++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_state: req=%b valid=%b required 0 0", IMemReq, InstrValid);
    end
    for (int i = 0; i < rsp_wait; i++) begin
      if (noise) Advance = 1'($urandom_range(0, 1));
      @(negedge CLK);
      Advance = 1'b0;
      n_tests++;
      if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
        n_fail++;
        $display("FAIL rsp_wait: req=%b valid=%b required 0 0", IMemReq, InstrValid);
      end
    end
    IMemRValid = 1'b1;
    IMemRData  = data;
    @(negedge CLK);
    IMemRValid = 1'b0;
    IMemRData  = $urandom;
    exp_instr  = data;
    n_tests++;
    if (InstrValid !== 1'b1 || Instr !== exp_instr) begin
      n_fail++;
      $display("FAIL instr: valid=%b instr=%h required 1 %h", InstrValid, Instr, exp_instr);
    end
    n_tests++;
    if (PC !== exp_pc || PCPlus4 !== exp_pc + 32'd4 || PCPlus8 !== exp_pc + 32'd8) begin
      n_fail++;
      $display("FAIL pc_outs: pc=%h p4=%h p8=%h required %h %h %h",
               PC, PCPlus4, PCPlus8, exp_pc, exp_pc + 32'd4, exp_pc + 32'd8);
    end
  endtask

  // Holds the instruction for `hold` cycles, then retires it with Advance.
  task automatic advance(input bit pcsrc, input logic [31:0] tgt,
                         input int hold, input bit noise);
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        IMemRValid = 1'b1;
        IMemRData  = $urandom;
      end
      @(negedge CLK);
      IMemRValid = 1'b0;
      n_tests++;
      if (InstrValid !== 1'b1 || Instr !== exp_instr) begin
        n_fail++;
        $display("FAIL hold: valid=%b instr=%h required 1 %h", InstrValid, Instr, exp_instr);
      end
    end
    Advance      = 1'b1;
    PCSrc        = pcsrc;
    BranchTarget = tgt;
    @(negedge CLK);
    Advance      = 1'b0;
    PCSrc        = 1'b0;
    BranchTarget = $urandom;
    exp_pc = pcsrc ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
    n_tests++;
    if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== exp_pc) begin
      n_fail++;
      $display("FAIL next_req: valid=%b req=%b addr=%h required 0 1 %h",
               InstrValid, IMemReq, IMemAddr, exp_pc);
    end
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    idle_inputs();
    #1;
    n_tests++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || PC !== 32'h0 || Instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b valid=%b pc=%h instr=%h required 0 0 0 0",
               IMemReq, InstrValid, PC, Instr);
    end
`ifdef FETCH_PERF_CNT_EN
    n_tests++;
    if (FetchCount !== 32'h0 || StallCount !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_perf: fetch=%0d stall=%0d required 0 0", FetchCount, StallCount);
    end
`endif
    repeat (2) @(negedge CLK);
    RESETn    = 1'b1;
    exp_pc    = 32'h0;
    exp_instr = 32'h0;
  endtask

  task automatic test_first_fetch();
    fetch_one(0, 0, 32'hE3A0_1005, 1'b0);
  endtask

  task automatic test_sequential_branch();
    advance(1'b1, 32'h0000_0010, 0, 1'b0);
    fetch_one(0, 0, 32'hE281_1001, 1'b0);
    advance(1'b0, 32'hDEAD_BEEF, 1, 1'b0);
    fetch_one(1, 0, 32'hE351_000A, 1'b0);
    advance(1'b1, 32'h0000_0103, 0, 1'b0);
  endtask

  task automatic test_grant_stall();
    fetch_one(4, 0, 32'h1A00_0004, 1'b1);
    advance(1'b0, 32'h0, 2, 1'b1);
  endtask

  task automatic test_wrap();
    fetch_one(0, 1, 32'hEAFF_FFFE, 1'b0);
    advance(1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    fetch_one(0, 0, 32'hE1A0_0000, 1'b0);
    n_tests++;
    if (PCPlus8 !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL wrap_p8: PCPlus8=%h required 00000004", PCPlus8);
    end
    advance(1'b0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    int guard = 0;
    while (IMemReq !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    IMemGnt = 1'b1;
    @(negedge CLK);
    IMemGnt = 1'b0;
    RESETn  = 1'b0;
    #1;
    n_tests++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || PC !== 32'h0 || Instr !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: req=%b valid=%b pc=%h instr=%h required 0 0 0 0",
               IMemReq, InstrValid, PC, Instr);
    end
    repeat (2) @(negedge CLK);
    RESETn     = 1'b1;
    exp_pc     = 32'h0;
    exp_instr  = 32'h0;
    IMemRValid = 1'b1;
    IMemRData  = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      IMemRValid = 1'b0;
      n_tests++;
      if (IMemReq !== 1'b1 || IMemAddr !== 32'h0 || InstrValid !== 1'b0 || Instr !== 32'h0) begin
        n_fail++;
        $display("FAIL stale_rsp: req=%b addr=%h valid=%b instr=%h required 1 0 0 0",
                 IMemReq, IMemAddr, InstrValid, Instr);
      end
    end
    fetch_one(0, 0, 32'hE3A0_2000, 1'b0);
    advance(1'b0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b1);
      advance(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2), 1'b1);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    apply_reset();
    n_tests++;
    if (FetchCount !== 32'h0 || StallCount !== 32'h0) begin
      n_fail++;
      $display("FAIL perf_clear: fetch=%0d stall=%0d required 0 0", FetchCount, StallCount);
    end
    for (int k = 0; k < 3; k++) begin
      if (k != 0) advance(1'b0, 32'h0, 0, 1'b0);
      fetch_one(2, 1, $urandom, 1'b0);
    end
    n_tests++;
    if (FetchCount !== 32'd3 || StallCount !== 32'd9) begin
      n_fail++;
      $display("FAIL perf_counts: fetch=%0d stall=%0d required 3 9", FetchCount, StallCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential_branch();
    test_grant_stall();
    test_wrap();
    test_reset_mid_wait();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the core's control/decode logic.
- Owns the PC and drives a variable-latency instruction memory through a request/grant/response handshake.
- Presents a registered instruction word (Cond/Op/Funct/Rd fields feed control), plus PC+4 and PC+8 (R15 read value) to the datapath.
- Consumes PCSrc and the branch target (Result) to redirect the PC when the current instruction retires.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, width of PC and instruction memory address.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESETn  input  1  asynchronous active-low reset.
- PCSrc  input  1  retiring instruction writes PC; take BranchTarget.
- BranchTarget  input  ADDR_W  redirect address (Result bus).
- Advance  input  1  core has finished executing the presented instruction.
- IMemReq  output  1  fetch request valid.
- IMemAddr  output  ADDR_W  fetch address, equals PC.
- IMemGnt  input  1  memory accepted request this cycle.
- IMemRValid  input  1  read data valid.
- IMemRData  input  32  read data.
- Instr  output  32  held instruction word.
- InstrValid  output  1  Instr is valid and awaits Advance.
- PC  output  ADDR_W  address of Instr.
- PCPlus4  output  ADDR_W  PC+4.
- PCPlus8  output  ADDR_W  PC+8.

Behaviour:
- Reset values (asynchronous, while RESETn=0):
  - PC=RESET_PC, Instr=32'h0, InstrValid=0, IMemReq=0, state=S_REQ.
  - Outputs are forced regardless of in-flight memory activity.
- States:
  - S_REQ: IMemReq=1, IMemAddr=PC. IMemGnt=1 -> S_WAIT; otherwise stay in S_REQ with address stable.
  - S_WAIT: IMemReq=0. IMemRValid=1 -> Instr<=IMemRData, InstrValid<=1, go to S_HOLD.
  - S_HOLD: InstrValid=1, Instr stable. Advance=1 -> PC<=PCSrc ? {BranchTarget[ADDR_W-1:2],2'b00} : PC+4; InstrValid<=0; go to S_REQ.
- Single outstanding request. IMemRValid in S_REQ or S_HOLD is ignored; this covers stale responses after reset.
- Advance with InstrValid=0 is ignored. PCSrc and BranchTarget are sampled only with an accepted Advance.
- Memory response latency is ≥1 cycle after grant; same-cycle grant+response is illegal.
- Timing:
  - Minimum 3 cycles per instruction: grant at t, RValid at t+1, InstrValid at t+2, Advance at t+2, next IMemReq at t+3.
  - Fetch latency from first IMemReq to InstrValid = 2 + grant wait + response wait.
- Arithmetic: PC+4 and PC+8 wrap modulo 2^ADDR_W (0xFFFF_FFFC+4=0x0000_0000). BranchTarget[1:0] is discarded.
- PCPlus4 and PCPlus8 are combinational from the PC register.
- Reset mid-S_WAIT: the request is abandoned; fetch restarts at RESET_PC on the first cycle after RESETn deasserts.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs FetchCount[31:0] (increments on each IMemRValid accepted in S_WAIT) and StallCount[31:0] (increments each cycle in S_REQ with IMemGnt=0 or in S_WAIT with IMemRValid=0).
  - Both are async-reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package arm_pkg:
  - fetch state enum {S_REQ,S_WAIT,S_HOLD}
  - INSTR_W=32
  - PC_STEP=4
  - default RESET_PC constant
- One natural sub-module: pc_register, an ADDR_W-bit async-active-low-reset register with load enable and reset value parameter. It is reused later for other architectural registers.

Test Plan:
- Reset release, memory grants immediately, 1-cycle response 32'hE3A01005 -> IMemAddr=0x0 in cycle 0; InstrValid=1, Instr=32'hE3A01005, PCPlus8=0x8 in cycle 2.
- Advance with PCSrc=0 at PC=0x10 -> next IMemAddr=0x14. Advance with PCSrc=1, BranchTarget=0x103 -> next IMemAddr=0x100.
- IMemGnt low for 4 cycles -> IMemReq held, IMemAddr stable; RValid pulsed during S_REQ -> Instr unchanged, InstrValid=0.
- PC=0xFFFF_FFFC, Advance, PCSrc=0 -> IMemAddr=0x0000_0000; PCPlus8 at 0xFFFF_FFFC reads 0x0000_0004.
- RESETn asserted during S_WAIT, response arrives after release -> response ignored, IMemReq=1 at RESET_PC, InstrValid=0 throughout.
- With FETCH_PERF_CNT_EN: 3 fetches, each with 2 grant-wait and 1 response-wait cycles -> FetchCount=3, StallCount=9.
